// File: rtl/aes_pkg.sv
// Shared constants and AES-128 helper functions: register map, identity words,
// S-box, Rcon and the SubBytes/ShiftRows/MixColumns transforms.
package aes_pkg;

  localparam logic [7:0] ADDR_NAME0   = 8'h00;
  localparam logic [7:0] ADDR_NAME1   = 8'h01;
  localparam logic [7:0] ADDR_VERSION = 8'h02;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_OPCOUNT = 8'h0b;
  localparam logic [7:0] ADDR_KEY0    = 8'h10;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
  localparam logic [7:0] ADDR_RESULT0 = 8'h30;

  localparam logic [31:0] NAME0   = 32'h61657320;  // "aes "
  localparam logic [31:0] NAME1   = 32'h31323820;  // "128 "
  localparam logic [31:0] VERSION = 32'h00010000;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  typedef enum logic {
    IDLE,
    ROUND
  } ctrl_state_t;

  // Byte 0x00 lives in the top byte so the table reads in FIPS-197 order.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 255 - int'(b);
    return SBOX[idx*8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 4; i++) o[32*i +: 32] = sub_word(s[32*i +: 32]);
    return o;
  endfunction

  // Byte n of the state (n = 4*col + row) sits at bits [127-8n -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 4; i++) o[32*i +: 32] = mix_column(s[32*i +: 32]);
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_key.sv
// On-the-fly AES-128 key schedule step: derives round key `round` from the
// previous round key.
module aes_round_key
  import aes_pkg::*;
(
  input  logic [127:0] round_key,
  input  logic [3:0]   round,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3, temp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    {w0, w1, w2, w3} = round_key;
    temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round), 24'h000000};
    n0 = w0 ^ temp;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_top.sv
// AES-128 encryption core with a 32-bit register interface.
// Define AES_OPCOUNT_EN to add a completed-encryption counter at 0x0B.
module aes_top
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);

  ctrl_state_t fsm, fsm_next;

  logic [127:0] key_reg, block_reg, result_reg;
  logic [127:0] state_reg, rk_reg;
  logic [127:0] next_key, round_out;
  logic [3:0]   cnt;
  logic         valid;
  logic         ready;
  logic         bus_write, start, finish;

  assign bus_write = cs & we;
  assign ready     = (fsm == IDLE);

  // Key schedule runs one step ahead of the rounds so each round uses a
  // registered key; cnt == 0 is the cycle that primes round key 1.
  aes_round_key u_round_key (
    .round_key (rk_reg),
    .round     (cnt + 4'd1),
    .next_key  (next_key)
  );

  always_comb begin
    logic [127:0] sr;
    sr = shift_rows(sub_bytes(state_reg));
    round_out = ((cnt == LAST_ROUND) ? sr : mix_columns(sr)) ^ rk_reg;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_next;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    fsm_next = fsm;
    start    = 1'b0;
    finish   = 1'b0;
    case (fsm)
      IDLE: begin
        if (bus_write && address == ADDR_CTRL && write_data[0]) begin
          start    = 1'b1;
          fsm_next = ROUND;
        end
      end
      ROUND: begin
        if (cnt == LAST_ROUND) begin
          finish   = 1'b1;
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  // NOTE: the working registers are plain flops, not memories, so they are
  // all cleared by reset; an abort therefore leaves no stale cipher state.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg    <= '0;
      block_reg  <= '0;
      result_reg <= '0;
      state_reg  <= '0;
      rk_reg     <= '0;
      cnt        <= '0;
      valid      <= 1'b0;
    end else begin
      if (bus_write && address[7:2] == ADDR_KEY0[7:2])
        key_reg[{address[1:0], 5'd0} +: 32] <= write_data;
      if (bus_write && address[7:2] == ADDR_BLOCK0[7:2])
        block_reg[{address[1:0], 5'd0} +: 32] <= write_data;

      if (start) begin
        state_reg <= block_reg ^ key_reg;
        rk_reg    <= key_reg;
        cnt       <= '0;
        valid     <= 1'b0;
      end else if (fsm == ROUND) begin
        rk_reg <= next_key;
        cnt    <= cnt + 4'd1;
        if (cnt != 4'd0) state_reg <= round_out;
        if (finish) begin
          result_reg <= round_out;
          valid      <= 1'b1;
        end
      end
    end
  end

`ifdef AES_OPCOUNT_EN
  logic [31:0] op_count;

  always_ff @(posedge clk) begin
    if (reset)       op_count <= '0;
    else if (finish) op_count <= op_count + 32'd1;
  end
`endif

  // Key words are deliberately absent: the key is write-only from the bus.
  always_comb begin
    read_data = '0;
    if (cs && !we) begin
      if (address[7:2] == ADDR_BLOCK0[7:2])
        read_data = block_reg[{address[1:0], 5'd0} +: 32];
      else if (address[7:2] == ADDR_RESULT0[7:2])
        read_data = result_reg[{address[1:0], 5'd0} +: 32];
      else begin
        case (address)
          ADDR_NAME0:   read_data = NAME0;
          ADDR_NAME1:   read_data = NAME1;
          ADDR_VERSION: read_data = VERSION;
          ADDR_STATUS:  read_data = {30'd0, valid, ready};
`ifdef AES_OPCOUNT_EN
          ADDR_OPCOUNT: read_data = op_count;
`endif
          default:      read_data = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top using FIPS-197 known-answer vectors and a
// queue of expected ciphertexts popped on each completion.
module tb_aes_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] FIPS_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_BLOCK = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZERO_CT    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_top dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = addr; write_data = data;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = addr;
    #1;
    data = read_data;
    cs = 1'b0;
  endtask

  task automatic write128(input logic [7:0] base, input logic [127:0] v);
    for (int i = 0; i < 4; i++) bus_write(base + 8'(i), v[32*i +: 32]);
  endtask

  task automatic read128(input logic [7:0] base, output logic [127:0] v);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      bus_read(base + 8'(i), w);
      v[32*i +: 32] = w;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Polls STATUS once per cycle until ready; returns the number of busy polls.
  task automatic wait_ready(output int busy);
    logic [31:0] s;
    busy = 0;
    bus_read(8'h09, s);
    while (!s[0] && busy < 60) begin
      busy++;
      bus_read(8'h09, s);
    end
    if (!s[0]) check("ready_timeout", {127'd0, s[0]}, 128'd1);
  endtask

  task automatic score_result();
    logic [31:0]  s;
    logic [127:0] res;
    bus_read(8'h09, s);
    check("status_done", s, 32'h3);
    read128(8'h30, res);
    if (exp_q.size() == 0) check("scoreboard_empty", res, 128'hx);
    else check("ciphertext", res, exp_q.pop_front());
  endtask

  initial begin
    logic [31:0]  w;
    logic [127:0] v;
    int           busy;

    reset = 1'b1; cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    bus_read(8'h09, w); check("reset_status", w, 32'h1);
    bus_read(8'h00, w); check("name0", w, 32'h61657320);
    bus_read(8'h01, w); check("name1", w, 32'h31323820);
    bus_read(8'h02, w); check("version", w, 32'h00010000);
    read128(8'h10, v);  check("reset_key_read", v, 128'd0);
    read128(8'h30, v);  check("reset_result", v, 128'd0);

    // FIPS-197 vector with exact latency measurement
    write128(8'h10, FIPS_KEY);
    write128(8'h20, FIPS_BLOCK);
    bus_read(8'h13, w); check("key_hidden", w, 32'h0);
    bus_read(8'h23, w); check("block_readback", w, 32'h00112233);
    bus_read(8'h44, w); check("unmapped_read", w, 32'h0);
    bus_write(8'h08, 32'h1);
    exp_q.push_back(FIPS_CT);
    wait_ready(busy);
    check("latency_busy_cycles", 128'(busy), 128'd11);
    score_result();

    // Strobe while busy and key/block rewritten mid-operation
    bus_write(8'h08, 32'h1);
    exp_q.push_back(FIPS_CT);
    bus_write(8'h08, 32'h1);
    write128(8'h10, 128'd0);
    write128(8'h20, 128'd0);
    wait_ready(busy);
    score_result();
    bus_read(8'h20, w); check("block_updated_midop", w, 32'h0);

    // CTRL write with bit0 clear must leave status and result alone
    bus_write(8'h08, 32'h0);
    bus_read(8'h09, w); check("ctrl_zero_status", w, 32'h3);
    bus_read(8'h33, w); check("ctrl_zero_result", w, 32'h69c4e0d8);

    // Second run picks up the new all-zero key and block
    bus_write(8'h08, 32'h1);
    exp_q.push_back(ZERO_CT);
    wait_ready(busy);
    check("latency_zero_run", 128'(busy), 128'd11);
    score_result();

    bus_read(8'h0b, w);
`ifdef AES_OPCOUNT_EN
    check("opcount", w, 32'd3);
`else
    check("opcount_absent", w, 32'd0);
`endif
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    // Reset five cycles into an operation aborts it
    write128(8'h20, FIPS_BLOCK);
    bus_write(8'h08, 32'h1);
    for (int i = 0; i < 5; i++) bus_read(8'h09, w);
    check("busy_before_abort", w, 32'h0);
    apply_reset();
    bus_read(8'h09, w); check("abort_status", w, 32'h1);
    read128(8'h30, v);  check("abort_result", v, 128'd0);
    bus_read(8'h20, w); check("abort_block", w, 32'h0);
    repeat (20) @(posedge clk);
    bus_read(8'h09, w); check("abort_no_completion", w, 32'h1);
    read128(8'h30, v);  check("abort_result_late", v, 128'd0);
    bus_read(8'h0b, w); check("abort_opcount", w, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
